rf_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32x32 register file. Shares the file's single write port between N_REQ write-back sources (ALU, load unit, CSR unit) using round-robin grant, registers the winning write into an output stage that drives write_en/waddr/wdata of the register file, and tracks which destination registers have writes in flight so decode can stall on hazards.

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_wb_arbiter_if.sv | 13 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 110 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-back request record.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bus between the N_REQ sources and the arbiter.
interface rf_wb_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int XLEN  = rf_pkg::XLEN
);
    logic [N_REQ-1:0]                         req_valid;
    logic [N_REQ-1:0][rf_pkg::REG_ADDR_W-1:0] req_waddr;
    logic [N_REQ-1:0][XLEN-1:0]               req_wdata;
    logic [N_REQ-1:0]                         req_ready;

    modport master (output req_valid, req_waddr, req_wdata, input req_ready);
    modport slave  (input req_valid, req_waddr, req_wdata, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rotated;
    logic [PTR_W:0] sum;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign dbl     = {req, req} >> ptr;
    assign rotated = dbl[N-1:0];

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && rotated[k]) begin
                grant_any = 1'b1;
                sum       = {1'b0, ptr} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N)) begin
                    sum = sum - (PTR_W+1)'(N);
                end
                grant_idx = sum[PTR_W-1:0];
            end
        end
        if (grant_any) begin
            grant = N'(1) << grant_idx;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant, registered write stage,
// and a pending-write scoreboard that decode uses for hazard stalls.
module rf_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEN  = rf_pkg::XLEN
) (
    input  logic                          clk,
    input  logic                          reset,
    rf_wb_arbiter_if.slave                wb,
    input  logic                          issue_valid,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rd,
    output logic                          rf_write_en,
    output logic [rf_pkg::REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic [rf_pkg::NUM_REGS-1:0]   busy
);
    localparam int AW    = rf_pkg::REG_ADDR_W;
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             write_en_reg, write_en_next;
    logic [AW-1:0]    waddr_reg, waddr_next;
    logic [XLEN-1:0]  wdata_reg, wdata_next;
    logic [rf_pkg::NUM_REGS-1:0] busy_reg, busy_next;

    logic [N_REQ-1:0] req_live;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             commit;

    logic [N_REQ-1:0][AW-1:0]   masked_waddr;
    logic [N_REQ-1:0][XLEN-1:0] masked_wdata;
    logic [AW-1:0]              win_waddr;
    logic [XLEN-1:0]            win_wdata;

    // Gating with reset keeps ready low for the whole time reset is asserted.
    assign req_live = wb.req_valid & {N_REQ{reset}};

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req       (req_live),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign wb.req_ready = grant;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign masked_waddr[gi] = grant[gi] ? wb.req_waddr[gi] : '0;
        assign masked_wdata[gi] = grant[gi] ? wb.req_wdata[gi] : '0;
    end

    always_comb begin
        win_waddr = '0;
        win_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_waddr = win_waddr | masked_waddr[i];
            win_wdata = win_wdata | masked_wdata[i];
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    assign commit = grant_any && (win_waddr != '0);

    always_comb begin
        rr_ptr_next   = rr_ptr_reg;
        write_en_next = commit;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        busy_next     = busy_reg;
        if (grant_any) begin
            rr_ptr_next = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
        if (commit) begin
            waddr_next = win_waddr;
            wdata_next = win_wdata;
        end
        if (write_en_reg) begin
            busy_next[waddr_reg] = 1'b0;
        end
        // Applied after the clear so a newly issued writer keeps the bit set.
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg   <= '0;
            write_en_reg <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            busy_reg     <= '0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            write_en_reg <= write_en_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            busy_reg     <= busy_next;
        end
    end

    assign rf_write_en = write_en_reg;
    assign rf_waddr    = waddr_reg;
    assign rf_wdata    = wdata_reg;
    assign busy        = busy_reg;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a turn-based model.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_write_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    rf_wb_arbiter_if #(.N_REQ(N), .XLEN(XLEN)) wb();

    rf_wb_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_write_en (rf_write_en),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model: whose turn it is, the pending register-file write, and the set of busy registers.
    int        m_turn;
    wb_req_t   m_wr;
    bit        m_en;
    bit [31:0] m_busy;
    logic [N-1:0] last_ready;
    int rr_exp[6] = '{1, 2, 3, 1, 2, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_turn = 0;
        m_en   = 0;
        m_wr   = '0;
        m_busy = '0;
    endtask

    function automatic int pick();
        if (reset !== 1'b1) return -1;
        for (int k = 0; k < N; k++) begin
            if (wb.req_valid[(m_turn + k) % N] === 1'b1) return (m_turn + k) % N;
        end
        return -1;
    endfunction

    // Compare the current cycle against the model, then advance both through one clock edge.
    task automatic step();
        int           g;
        logic [N-1:0] er;
        bit [31:0]    nb;
        wb_req_t      w;
        #1;
        g  = pick();
        er = (g < 0) ? '0 : (N'(1) << g);
        check("req_ready",   32'(wb.req_ready), 32'(er));
        check("rf_write_en", 32'(rf_write_en), 32'(m_en));
        check("rf_waddr",    32'(rf_waddr), 32'(m_wr.waddr));
        check("rf_wdata",    rf_wdata, m_wr.wdata);
        check("busy",        busy, m_busy);
        last_ready = wb.req_ready;
        nb = m_busy;
        if (m_en) nb[m_wr.waddr] = 1'b0;
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        w = '0;
        if (g >= 0) begin
            w.waddr = wb.req_waddr[g];
            w.wdata = wb.req_wdata[g];
            $display("grant req%0d x%0d <= %h", g, w.waddr, w.wdata);
        end
        @(posedge clk);
        if (reset !== 1'b1) begin
            model_reset();
        end else begin
            m_busy = nb;
            m_en   = 0;
            if (g >= 0) begin
                m_turn = (g + 1) % N;
                if (w.waddr != 0) begin
                    m_en = 1;
                    m_wr = w;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (wb.req_valid[i] && last_ready[i]) wb.req_valid[i] = 1'b0;
            if (!wb.req_valid[i] && $urandom_range(0, 2) != 0) begin
                wb.req_valid[i] = 1'b1;
                wb.req_waddr[i] = 5'($urandom_range(0, 31));
                wb.req_wdata[i] = $urandom;
            end
        end
        issue_valid = ($urandom_range(0, 2) == 0);
        issue_rd    = 5'($urandom_range(0, 31));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        wb.req_valid = '1;
        for (int i = 0; i < N; i++) begin
            wb.req_waddr[i] = 5'(i + 1);
            wb.req_wdata[i] = 32'h1111_0000 + 32'(i);
        end
        model_reset();
        last_ready = '0;
        @(negedge clk);

        // Reset held with every requester valid
        repeat (3) step();
        check("rst_ready", 32'(wb.req_ready), 32'h0);
        check("rst_wen",   32'(rf_write_en), 32'h0);
        check("rst_busy",  busy, 32'h0);
        reset = 1'b1;
        #1 check("first_grant", 32'(wb.req_ready), 32'h1);

        // Round-robin with all three valid
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rr_wen%0d", k), 32'(rf_write_en), 32'h1);
            check($sformatf("rr_addr%0d", k), 32'(rf_waddr), 32'(rr_exp[k]));
        end

        // Lone requester 2
        wb.req_valid = 3'b100; wb.req_waddr[2] = 5'd7; wb.req_wdata[2] = 32'hDEADBEEF;
        #1 check("single_ready", 32'(wb.req_ready), 32'h4);
        step();
        check("single_wen",  32'(rf_write_en), 32'h1);
        check("single_addr", 32'(rf_waddr), 32'h7);
        check("single_data", rf_wdata, 32'hDEADBEEF);
        wb.req_valid = '0;
        step();

        // Scoreboard set then clear of x5
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        issue_valid = 1'b0;
        check("sb_set5", 32'(busy[5]), 32'h1);
        step(); step();
        wb.req_valid = 3'b001; wb.req_waddr[0] = 5'd5; wb.req_wdata[0] = 32'h0000_0055;
        step();
        wb.req_valid = '0;
        check("sb_wen5",  32'(rf_write_en), 32'h1);
        check("sb_addr5", 32'(rf_waddr), 32'h5);
        check("sb_hold5", 32'(busy[5]), 32'h1);
        step();
        check("sb_clr5", 32'(busy[5]), 32'h0);

        // Commit of x9 coinciding with a new issue of x9
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        wb.req_valid = 3'b010; wb.req_waddr[1] = 5'd9; wb.req_wdata[1] = 32'h0000_0099;
        step();
        wb.req_valid = '0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        check("collide_busy9", 32'(busy[9]), 32'h1);
        check("collide_busy",  busy, 32'h0000_0200);

        // Issue to x0, then a write to x0
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        issue_valid = 1'b0;
        check("x0_issue_busy", busy, 32'h0000_0200);
        wb.req_valid = 3'b001; wb.req_waddr[0] = 5'd0; wb.req_wdata[0] = 32'h1234_5678;
        #1 check("x0_ready", 32'(wb.req_ready), 32'h1);
        step();
        wb.req_valid = '0;
        check("x0_wen",  32'(rf_write_en), 32'h0);
        check("x0_busy", busy, 32'h0000_0200);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            drive_random();
            step();
        end

        // Asynchronous reset between edges during sustained writes
        issue_valid = 1'b0;
        wb.req_valid = '1;
        for (int i = 0; i < N; i++) wb.req_waddr[i] = 5'(10 + i);
        step(); step();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_ready", 32'(wb.req_ready), 32'h0);
        check("arst_wen",   32'(rf_write_en), 32'h0);
        check("arst_addr",  32'(rf_waddr), 32'h0);
        check("arst_data",  rf_wdata, 32'h0);
        check("arst_busy",  busy, 32'h0);
        model_reset();
        @(negedge clk);
        step();
        reset = 1'b1;
        #1 check("arst_first_grant", 32'(wb.req_ready), 32'h1);
        repeat (4) step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
